// File: rtl/gpu_pkg.sv
// gpu_pkg: shared types, defaults and FSM encoding for the fragment write-back stage
package gpu_pkg;
    localparam int GPU_DATA_W    = 32;
    localparam int GPU_CORD_W    = 10;
    localparam int GPU_ADDR_W    = 32;
    localparam int FB_WIDTH_DEF  = 640;
    localparam int FB_HEIGHT_DEF = 480;
    typedef struct packed {
        logic [GPU_CORD_W-1:0] x;
        logic [GPU_CORD_W-1:0] y;
        logic [GPU_DATA_W-1:0] color;
    } frag_t;
    typedef struct packed {
        logic [GPU_ADDR_W-1:0] addr;
        logic [GPU_DATA_W-1:0] data;
    } fb_wr_t;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE
    } wr_state_e;
endpackage

// File: rtl/frag_fifo.sv
// frag_fifo: synchronous FIFO shared by the pipeline buffers
//   clk, rst       : clock, synchronous active-high reset (flushes contents)
//   data_i, push_i : write port; a push while full is dropped even if a pop happens too
//   data_o, pop_i  : head entry and pop strobe; a pop while empty is ignored
//   full_o, empty_o, count_o : occupancy status
module frag_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/frag_fb_writer.sv
// frag_fb_writer: fragment write-back stage, turns (x, y, colour) into framebuffer DRAM writes
//   clk, rst                      : clock, synchronous active-high reset
//   i_fb_base                     : framebuffer base byte address
//   i_frag_valid/o_frag_ready     : fragment handshake with i_frag_x, i_frag_y, i_frag_color
//   o_dram_req/i_dram_gnt         : request/grant with the shared DRAM arbiter
//   o_dram_we/addr/wdata          : single-beat 32-bit write, addr/data zero when not writing
//   o_idle                        : buffer empty and FSM idle
//   o_pix_count, o_clip_count     : pixels written, fragments discarded by clipping
// Optional feature: define FRAG_WRITER_CLIP_EN to drop off-screen fragments and count them.
module frag_fb_writer
    import gpu_pkg::*;
#(
    parameter int DATA_WIDTH = GPU_DATA_W,
    parameter int CORD_WIDTH = GPU_CORD_W,
    parameter int FB_WIDTH   = FB_WIDTH_DEF,
    parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_fb_base,
    input  logic                  i_frag_valid,
    output logic                  o_frag_ready,
    input  logic [CORD_WIDTH-1:0] i_frag_x,
    input  logic [CORD_WIDTH-1:0] i_frag_y,
    input  logic [DATA_WIDTH-1:0] i_frag_color,
    output logic                  o_dram_req,
    input  logic                  i_dram_gnt,
    output logic                  o_dram_we,
    output logic [31:0]           o_dram_addr,
    output logic [DATA_WIDTH-1:0] o_dram_wdata,
    output logic                  o_idle,
    output logic [31:0]           o_pix_count,
    output logic [31:0]           o_clip_count
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    frag_t        frag;
    fb_wr_t       wr_in, wr_head;
    logic [31:0]  pix_idx;
    logic         clipped, accept, push, pop, full, empty;
    logic [CW-1:0] count;
    wr_state_e    state_q, state_d;
    logic [31:0]  pix_count_q;

    assign frag    = '{x: GPU_CORD_W'(i_frag_x), y: GPU_CORD_W'(i_frag_y), color: GPU_DATA_W'(i_frag_color)};
    assign pix_idx = 32'(frag.y) * 32'(FB_WIDTH) + 32'(frag.x);
    assign wr_in   = '{addr: i_fb_base + (pix_idx << 2), data: frag.color};
    assign accept  = i_frag_valid && o_frag_ready;
    assign push    = accept && !clipped;
    assign pop     = o_dram_we;

    frag_fifo #(
        .WIDTH ($bits(fb_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .data_i  (wr_in),
        .push_i  (push),
        .pop_i   (pop),
        .data_o  (wr_head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // WRITE keeps going only while an entry beyond the current head is already held.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = empty ? ST_IDLE : ST_REQ;
            ST_REQ:   state_d = i_dram_gnt ? ST_WRITE : ST_REQ;
            ST_WRITE: state_d = count > CW'(1) ? (i_dram_gnt ? ST_WRITE : ST_REQ) : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pix_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pix_count_q <= pop ? pix_count_q + 1 : pix_count_q;
        end
    end

    assign o_frag_ready = !full;
    assign o_dram_req   = state_q != ST_IDLE;
    assign o_dram_we    = state_q == ST_WRITE;
    assign o_dram_addr  = o_dram_we ? wr_head.addr : '0;
    assign o_dram_wdata = o_dram_we ? DATA_WIDTH'(wr_head.data) : '0;
    assign o_idle       = empty && state_q == ST_IDLE;
    assign o_pix_count  = pix_count_q;

`ifdef FRAG_WRITER_CLIP_EN
    logic [31:0] clip_count_q;
    assign clipped = 32'(frag.x) >= 32'(FB_WIDTH) || 32'(frag.y) >= 32'(FB_HEIGHT);
    always_ff @(posedge clk) begin
        if (rst) clip_count_q <= '0;
        else     clip_count_q <= (accept && clipped) ? clip_count_q + 1 : clip_count_q;
    end
    assign o_clip_count = clip_count_q;
`else
    logic unused_cfg;
    assign clipped      = 1'b0;
    assign o_clip_count = '0;
    assign unused_cfg   = ^32'(FB_HEIGHT);
`endif
endmodule

// File: tb/tb_frag_fb_writer.sv
// tb_frag_fb_writer: directed table-driven bench for frag_fb_writer
module tb_frag_fb_writer;
    logic        clk = 1'b0;
    logic        rst, valid, ready, req, gnt, we, idle;
    logic [31:0] base, addr, wdata, pix, clip;
    logic [9:0]  fx, fy;
    logic [31:0] color;
    int          n_cmp = 0, n_bad = 0, nw = 0;
    logic [31:0] exp_a[$], exp_d[$];

`ifdef FRAG_WRITER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct {
        logic [31:0] base;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [31:0] color;
        logic [31:0] addr;
        bit          oob;
    } vec_t;

    always #5 clk = ~clk;

    frag_fb_writer dut (
        .clk          (clk),
        .rst          (rst),
        .i_fb_base    (base),
        .i_frag_valid (valid),
        .o_frag_ready (ready),
        .i_frag_x     (fx),
        .i_frag_y     (fy),
        .i_frag_color (color),
        .o_dram_req   (req),
        .i_dram_gnt   (gnt),
        .o_dram_we    (we),
        .o_dram_addr  (addr),
        .o_dram_wdata (wdata),
        .o_idle       (idle),
        .o_pix_count  (pix),
        .o_clip_count (clip)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] fa(input logic [31:0] b, input int x, input int y);
        return b + 32'((y * 640 + x) * 4);
    endfunction

    task automatic beat();
        if (we) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_write: got addr %h want no write", addr);
            end else begin
                chk("burst_addr", addr, exp_a.pop_front());
                chk("burst_data", wdata, exp_d.pop_front());
            end
            nw++;
        end else chk("idle_bus_zero", addr | wdata, 32'h0);
    endtask

    task automatic push_frag(input int x, input int y, input logic [31:0] c, input logic [31:0] b);
        @(negedge clk);
        fx = 10'(x);
        fy = 10'(y);
        color = c;
        base = b;
        valid = 1'b1;
        chk("push_ready", 32'(ready), 32'h1);
        exp_a.push_back(fa(b, x, y));
        exp_d.push_back(c);
    endtask

    initial begin
        vec_t        vt[8];
        logic [31:0] pix_exp, clip_exp;
        bit          oob, pending, acc;
        int          first, c8;
        vt[0] = '{32'h10010000, 10'd20,   10'd20,   32'hFFFF0000, 32'h1001C850, 1'b0};
        vt[1] = '{32'h10010000, 10'd639,  10'd479,  32'h12345678, 32'h1013BFFC, 1'b0};
        vt[2] = '{32'h00000000, 10'd0,    10'd0,    32'hA5A5A5A5, 32'h00000000, 1'b0};
        vt[3] = '{32'h80000000, 10'd1,    10'd0,    32'h00000001, 32'h80000004, 1'b0};
        vt[4] = '{32'hFFFFFFFC, 10'd0,    10'd1,    32'h5A5A5A5A, 32'h000009FC, 1'b0};
        vt[5] = '{32'h10010000, 10'd640,  10'd0,    32'hDEADBEEF, 32'h10010A00, 1'b1};
        vt[6] = '{32'h00000000, 10'd1023, 10'd1023, 32'hCAFEF00D, 32'h002805FC, 1'b1};
        vt[7] = '{32'h10010000, 10'd0,    10'd480,  32'h0BADCAFE, 32'h1013C000, 1'b1};
        rst = 1'b1; valid = 1'b0; gnt = 1'b0; base = '0; fx = '0; fy = '0; color = '0;
        pix_exp = 0; clip_exp = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_bus", addr | wdata, 32'h0);
        chk("rst_pix", pix, 32'h0);
        chk("rst_clip", clip, 32'h0);
        rst = 1'b0;
        gnt = 1'b1;

        // single fragments through an empty pipe with grant held high
        for (int i = 0; i < 8; i++) begin
            oob = CLIP && vt[i].oob;
            @(negedge clk);
            base = vt[i].base; fx = vt[i].x; fy = vt[i].y; color = vt[i].color; valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            chk("vec_idle_after_push", 32'(idle), 32'(oob));
            chk("vec_req_after_push", 32'(req), 32'h0);
            @(negedge clk);
            chk("vec_req", 32'(req), 32'(!oob));
            chk("vec_we_early", 32'(we), 32'h0);
            @(negedge clk);
            chk("vec_we", 32'(we), 32'(!oob));
            chk("vec_addr", addr, oob ? 32'h0 : vt[i].addr);
            chk("vec_data", wdata, oob ? 32'h0 : vt[i].color);
            pix_exp += 32'(!oob);
            clip_exp += 32'(oob);
            @(negedge clk);
            chk("vec_we_done", 32'(we), 32'h0);
            chk("vec_idle_done", 32'(idle), 32'h1);
            chk("vec_pix", pix, pix_exp);
            chk("vec_clip", clip, clip_exp);
        end

        // backpressure: 8 accepted with no grant, 9th held until a slot frees
        gnt = 1'b0;
        nw = 0;
        for (int k = 0; k < 8; k++) push_frag(k * 3, k + 1, 32'hC0DE0000 | 32'(k), 32'h20000000);
        @(negedge clk);
        fx = 10'd24; fy = 10'd9; color = 32'hC0DE0008; valid = 1'b1;
        exp_a.push_back(fa(32'h20000000, 24, 9));
        exp_d.push_back(32'hC0DE0008);
        chk("full_ready", 32'(ready), 32'h0);
        chk("full_req", 32'(req), 32'h1);
        chk("full_no_we", 32'(we), 32'h0);
        @(negedge clk);
        chk("full_hold", 32'(ready), 32'h0);
        chk("full_idle", 32'(idle), 32'h0);
        gnt = 1'b1;
        pending = 1'b1; acc = 1'b0; first = -1; c8 = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc) begin
                valid = 1'b0;
                pending = 1'b0;
                acc = 1'b0;
            end
            if (we && nw == 0) first = c;
            if (we && nw == 7) c8 = c;
            beat();
            if (pending && ready) acc = 1'b1;
            if (nw == 9 && idle) break;
        end
        pix_exp += 9;
        chk("burst_writes", 32'(nw), 32'd9);
        chk("burst_consecutive", 32'(c8 - first), 32'd7);
        chk("burst_idle", 32'(idle), 32'h1);
        chk("burst_pix", pix, pix_exp);
        chk("burst_ready", 32'(ready), 32'h1);

        // grant dropped mid-burst, then restored
        gnt = 1'b0;
        nw = 0;
        for (int k = 0; k < 4; k++) push_frag(100 + k, 200, 32'hBEEF0000 | 32'(k), 32'h30000000);
        @(negedge clk);
        valid = 1'b0;
        gnt = 1'b1;
        for (int c = 0; c < 20 && nw < 2; c++) begin
            @(negedge clk);
            beat();
        end
        gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("drop_we", 32'(we), 32'h0);
            chk("drop_req", 32'(req), 32'h1);
        end
        chk("drop_pix", pix, pix_exp + 2);
        gnt = 1'b1;
        for (int c = 0; c < 20 && !(nw == 4 && idle); c++) begin
            @(negedge clk);
            beat();
        end
        pix_exp += 4;
        chk("regrant_writes", 32'(nw), 32'd4);
        chk("regrant_left", 32'(exp_a.size()), 32'd0);
        chk("regrant_pix", pix, pix_exp);
        chk("regrant_idle", 32'(idle), 32'h1);

        // reset while a burst is in flight
        gnt = 1'b0;
        nw = 0;
        for (int k = 0; k < 4; k++) push_frag(k, 7, 32'h77770000 | 32'(k), 32'h40000000);
        @(negedge clk);
        valid = 1'b0;
        gnt = 1'b1;
        for (int c = 0; c < 20 && nw < 1; c++) begin
            @(negedge clk);
            beat();
        end
        chk("pre_rst_writes", 32'(nw), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_a.delete();
        exp_d.delete();
        chk("post_rst_ready", 32'(ready), 32'h1);
        chk("post_rst_idle", 32'(idle), 32'h1);
        chk("post_rst_req", 32'(req), 32'h0);
        chk("post_rst_pix", pix, 32'h0);
        chk("post_rst_clip", clip, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_we", 32'(we), 32'h0);
            chk("post_rst_idle_hold", 32'(idle), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
